risc_fetch_queue: RTL and testbench

//  Parametrised successor to the single-register instruction unit. Owns the PC, issues fetches to a

---
 rtl/risc_fetch_queue_pkg.sv | 19 +
 rtl/risc_fetch_queue_if.sv | 38 +++
 rtl/risc_fetch_queue_fifo.sv | 85 ++++++++
 rtl/risc_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_risc_fetch_queue.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/risc_fetch_queue_pkg.sv
// risc_pkg: shared definitions for the RISC fetch path.
// Holds the default instruction/opcode/PC widths, the HALT opcode value
// and the fetch FSM state encoding used by risc_fetch_queue.
// Optional feature macro used by the fetch unit: RISC_FETCH_HALT_EN.
package risc_pkg;

  localparam int IW  = 13;
  localparam int OPW = 5;
  localparam int PCW = 8;

  localparam logic [4:0] HALT_OP = 5'h1F;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/risc_fetch_queue_if.sv
// risc_fetch_queue_if: bundles the instruction-ROM port, the redirect
// input and the decode-side valid/ready handshake of the fetch unit.
//   imem_req/imem_addr/imem_rdata : synchronous ROM port (1-cycle latency)
//   redirect/redirect_pc          : PC redirect with queue flush
//   ir_valid/ir_ready/ir/ir_pc/ir_opcode : head of the prefetch queue
//   halted                        : fetch stopped on HALT (RISC_FETCH_HALT_EN)
// master = fetch unit, slave = surrounding core/memory.
interface risc_fetch_queue_if
  import risc_pkg::*;
#(
  parameter int IW  = risc_pkg::IW,
  parameter int OPW = risc_pkg::OPW,
  parameter int PCW = risc_pkg::PCW
);

  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic [IW-1:0]  imem_rdata;
  logic           redirect;
  logic [PCW-1:0] redirect_pc;
  logic           ir_valid;
  logic           ir_ready;
  logic [IW-1:0]  ir;
  logic [PCW-1:0] ir_pc;
  logic [OPW-1:0] ir_opcode;
  logic           halted;

  modport master (
    output imem_req, imem_addr, ir_valid, ir, ir_pc, ir_opcode, halted,
    input  imem_rdata, redirect, redirect_pc, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir, ir_pc, ir_opcode, halted,
    output imem_rdata, redirect, redirect_pc, ir_ready
  );

endinterface

// File: rtl/risc_fetch_queue_fifo.sv
// risc_fetch_fifo: DEPTH x W synchronous FIFO holding {pc, instruction}
// words for the fetch unit. flush_i empties it on the next edge and wins
// over push/pop. DEPTH must be a power of two so the pointers wrap freely.
//   clk, rst           : clock, synchronous active-high reset
//   flush_i            : discard all entries
//   push_i / wdata_i   : write at tail
//   pop_i              : remove head
//   rdata_o            : head entry
//   count_o / empty_o  : occupancy
// risc_fetch_fifo_chk flags a push into a full queue without a pop.
module risc_fetch_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  risc_fetch_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_i),
    .pop_i   (pop_i),
    .flush_i (flush_i),
    .count_i (count_q)
  );

endmodule

// risc_fetch_fifo_chk: overflow watchdog for risc_fetch_fifo.
module risc_fetch_fifo_chk #(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  input logic          push_i,
  input logic          pop_i,
  input logic          flush_i,
  input logic [CW-1:0] count_i
);

  localparam logic [CW-1:0] FULL_W = CW'(DEPTH);

  // Upstream credit accounting must never push into a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && (count_i == FULL_W)));

endmodule

// File: rtl/risc_fetch_queue.sv
// risc_fetch_queue: instruction fetch unit with a DEPTH-entry prefetch
// queue. Owns the fetch PC, issues requests to a 1-cycle synchronous ROM
// under a credit rule (queued + in-flight < DEPTH), pushes {pc, word} into
// risc_fetch_fifo and presents the head to decode via valid/ready.
// A redirect reloads the PC, flushes the queue and squashes any in-flight
// response.
//   clk, rst : clock, synchronous active-high reset
//   bus      : risc_fetch_queue_if.master (ROM port, redirect, decode side)
// Optional: RISC_FETCH_HALT_EN stops issue when a HALT_OP word is pushed.
module risc_fetch_queue
  import risc_pkg::*;
#(
  parameter int IW                 = risc_pkg::IW,
  parameter int OPW                = risc_pkg::OPW,
  parameter int PCW                = risc_pkg::PCW,
  parameter int DEPTH              = 4,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  risc_fetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PCW + IW;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_e   state_q, state_d;
  logic [PCW-1:0] fetch_pc_q, fetch_pc_d;
  logic           inflight_q, inflight_d;
  logic [PCW-1:0] inflight_pc_q, inflight_pc_d;

  logic [CW-1:0]  count_s;
  logic           empty_s;
  logic [EW-1:0]  head_s;
  logic           credit_ok_s;
  logic           push_s;
  logic           pop_s;
  logic           issue_s;
  logic           halt_hit_s;
  logic [IW-1:0]  ir_s;

  // A response is squashed when a redirect arrives in the cycle it returns.
  assign push_s      = inflight_q & ~bus.redirect;
  assign credit_ok_s = ({1'b0, count_s} + {{CW{1'b0}}, inflight_q}) < DEPTH_W;
  assign pop_s       = ~empty_s & bus.ir_ready;

`ifdef RISC_FETCH_HALT_EN
  assign halt_hit_s  = push_s && (bus.imem_rdata[IW-1 -: OPW] == OPW'(HALT_OP));
`else
  assign halt_hit_s  = 1'b0;
`endif

  // State, PC and in-flight tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Next-state, issue decision and redirect override.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    issue_s       = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Issue is suppressed on the HALT push so nothing follows HALT.
        if (!bus.redirect && credit_ok_s && !halt_hit_s) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
        if (halt_hit_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
`ifdef RISC_FETCH_HALT_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    if (issue_s) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 1'b1;
    end else begin
      inflight_d    = 1'b0;
    end
    // Redirect beats issue, push and HALT entry, and leaves HALT.
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      inflight_d = 1'b0;
      state_d    = ST_RUN;
    end else begin
      fetch_pc_d = fetch_pc_d;
    end
  end

  risc_fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({inflight_pc_q, bus.imem_rdata}),
    .rdata_o (head_s),
    .count_o (count_s),
    .empty_o (empty_s)
  );

  assign ir_s          = empty_s ? '0 : head_s[IW-1:0];
  assign bus.imem_req  = issue_s;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.ir_valid  = ~empty_s;
  assign bus.ir        = ir_s;
  assign bus.ir_pc     = empty_s ? '0 : head_s[EW-1:IW];
  assign bus.ir_opcode = ir_s[IW-1 -: OPW];
`ifdef RISC_FETCH_HALT_EN
  assign bus.halted    = (state_q == ST_HALT);
`else
  assign bus.halted    = 1'b0;
`endif

endmodule

// File: tb/tb_risc_fetch_queue.sv
// Testbench for risc_fetch_queue. A ROM model answers one cycle after each
// address; a scoreboard tracks the next PC decode should see (sequential
// increment, reloaded on redirect or reset) and checks every accepted word.
module tb_risc_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  risc_fetch_queue_if bus ();
  risc_fetch_queue_if bus2 ();

  risc_fetch_queue #(.DEPTH(4), .RESET_PC(8'h00)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  risc_fetch_queue #(.DEPTH(4), .RESET_PC(8'hFE)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  logic [12:0] rom [256];

  // Synchronous ROM models: data for the address presented one cycle earlier.
  always @(posedge clk) begin
    bus.imem_rdata  <= rom[bus.imem_addr];
    bus2.imem_rdata <= rom[bus2.imem_addr];
  end

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_pc;
  int n_acc;
  int n_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs, update the reference.
  task automatic cyc(input logic rdy, input logic rd, input logic [7:0] tgt);
    logic [12:0] w;
    bus.ir_ready    = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = tgt;
    #1;
    if (!bus.ir_valid) begin
      chk("ir_idle_zero", 32'(bus.ir), 32'h0);
      chk("ir_pc_idle_zero", 32'(bus.ir_pc), 32'h0);
    end
    if (rd) chk("no_req_on_redirect", 32'(bus.imem_req), 32'h0);
`ifndef RISC_FETCH_HALT_EN
    chk("halted_tied_low", 32'(bus.halted), 32'h0);
`endif
    if (bus.ir_valid && rdy) begin
      w = rom[exp_pc];
      chk("ir_pc_order", 32'(bus.ir_pc), 32'(exp_pc));
      chk("ir_word", 32'(bus.ir), 32'(w));
      chk("ir_opcode", 32'(bus.ir_opcode), 32'(w[12:8]));
      exp_pc = exp_pc + 8'd1;
      n_acc++;
    end
    if (rd) exp_pc = tgt;
    if (bus.imem_req) n_req++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.ir_ready = 1'b0;
    bus.redirect = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
      chk("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
      chk("rst_ir", 32'(bus.ir), 32'h0);
      chk("rst_ir_pc", 32'(bus.ir_pc), 32'h0);
      chk("rst_halted", 32'(bus.halted), 32'h0);
    end
    rst = 1'b0;
    exp_pc = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {5'(i % 31), 8'(i)};
    rom[0]  = 13'h0208;
    rom[1]  = 13'h05f1;
    rom[2]  = 13'h06aa;
    rom[12] = 13'h1b04;
`ifndef RISC_FETCH_HALT_EN
    rom[20] = 13'h1F14;
`endif
    bus.ir_ready     = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 8'h00;
    bus2.ir_ready    = 1'b1;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 8'h00;

    // Start-up latency, in-order streaming, and RESET_PC wrap on the second unit.
    do_reset(2);
    for (int k = 0; k < 16; k++) begin
      chk("startup_valid", 32'(bus.ir_valid), (k < 3) ? 32'h0 : 32'h1);
      if (k >= 3 && k < 7) begin
        chk("wrap_valid", 32'(bus2.ir_valid), 32'h1);
        chk("wrap_pc", 32'(bus2.ir_pc), 32'(8'(8'hFE + 8'(k - 3))));
      end
      cyc(1'b1, 1'b0, 8'h00);
    end

    // Decode stalled from reset: exactly DEPTH requests, then silence.
    do_reset(1);
    n_req = 0;
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 8'h00);
    chk("stall_req_count", 32'(n_req), 32'd4);
    chk("stall_req_low", 32'(bus.imem_req), 32'h0);
    chk("stall_valid", 32'(bus.ir_valid), 32'h1);
    n_acc = 0;
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, 8'h00);
    chk("release_progress", 32'(exp_pc), 32'(8'(n_acc)));

    // Redirect with a handshake in the same cycle; flush then refill.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h40);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("redir_valid", 32'(bus.ir_valid), 32'h1);
    chk("redir_pc", 32'(bus.ir_pc), 32'h40);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 8'h00);

    // Random backpressure and redirects against the reference stream.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 8'($urandom));
    end

    // Reset pulsed mid-stream.
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 8'h00);
    chk("pre_rst_valid", 32'(bus.ir_valid), 32'h1);
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      chk("restart_valid", 32'(bus.ir_valid), (k < 3) ? 32'h0 : 32'h1);
      cyc(1'b1, 1'b0, 8'h00);
    end

`ifdef RISC_FETCH_HALT_EN
    // HALT word at pc 3: drain 0..3, stop issuing, redirect resumes.
    rom[3] = 13'h1F00;
    do_reset(2);
    n_acc = 0;
    for (int k = 0; k < 14; k++) cyc(1'b1, 1'b0, 8'h00);
    chk("halt_delivered", 32'(n_acc), 32'd4);
    chk("halt_next_pc", 32'(exp_pc), 32'h4);
    chk("halted_set", 32'(bus.halted), 32'h1);
    n_req = 0;
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'h00);
    chk("halt_no_req", 32'(n_req), 32'h0);
    chk("halt_drained", 32'(bus.ir_valid), 32'h0);
    cyc(1'b1, 1'b1, 8'h00);
    chk("halt_left", 32'(bus.halted), 32'h0);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("halt_restart_pc", 32'(bus.ir_pc), 32'h0);
    chk("halt_restart_valid", 32'(bus.ir_valid), 32'h1);
    rom[3] = {5'd3, 8'd3};
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
